// File: rtl/tt_um_seq_divider_8by4.sv
// Sequential restoring divider tile: 8-bit dividend / 4-bit divisor.
// One quotient bit resolves per clock, behind a start/busy/done handshake.
module tt_um_seq_divider_8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  dq_q;
  logic [3:0]  dv_q;
  logic [4:0]  pr_q;
  logic [3:0]  dvd_lo_q;
  logic [3:0]  cnt_q;
  logic [7:0]  quot_q;
  logic [3:0]  rem_q;
  logic        dbz_q;
  logic        busy_q;
  logic        done_q;

  logic        start;
  logic        rsel;
  logic [3:0]  divisor;
  logic [4:0]  t_d;
  logic        qbit_d;
  logic [4:0]  pr_d;
  logic [7:0]  dq_d;

  assign divisor = uio_in[3:0];
  assign start   = uio_in[4];
  assign rsel    = uio_in[5];

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    t_d    = {pr_q[3:0], dq_q[7]};
    qbit_d = (t_d >= {1'b0, dv_q});
    pr_d   = qbit_d ? (t_d - {1'b0, dv_q}) : t_d;
    dq_d   = {dq_q[6:0], qbit_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dq_q     <= 8'd0;
      dv_q     <= 4'd0;
      pr_q     <= 5'd0;
      dvd_lo_q <= 4'd0;
      cnt_q    <= 4'd0;
      quot_q   <= 8'd0;
      rem_q    <= 4'd0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dq_q     <= ui_in;
            dv_q     <= divisor;
            dvd_lo_q <= ui_in[3:0];
            pr_q     <= 5'd0;
            cnt_q    <= 4'd0;
            state_q  <= RUN;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        RUN: begin
          dq_q  <= dq_d;
          pr_q  <= pr_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // A zero divisor still takes full latency, then reports a fixed result.
            if (dv_q == 4'd0) begin
              quot_q <= 8'hFF;
              rem_q  <= dvd_lo_q;
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= dq_d;
              rem_q  <= pr_d[3:0];
              dbz_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uo_out  = rsel ? {dbz_q, 3'b000, rem_q} : quot_q;
  assign uio_out = {done_q, busy_q, 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_seq_divider_8by4.sv
// Bench for the sequential divider tile: driver pushes expected results,
// a monitor pops and compares them whenever done rises.
module tb_tt_um_seq_divider_8by4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       start = 1'b0;
  logic       rsel = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign uio_in = {2'b00, rsel, start, divisor};

  tt_um_seq_divider_8by4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];   // {quotient, rsel=1 view}
  logic [7:0]  prev_quot = 8'd0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic        done_prev = 1'b0;
  logic [15:0] mon_e;
  always @(posedge clk) begin
    #2;
    if (rst_n && uio_out[7] === 1'b1 && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no result at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        rsel = 1'b0;
        #1;
        check8("quotient", uo_out, mon_e[15:8]);
        rsel = 1'b1;
        #1;
        check8("rem_view", uo_out, mon_e[7:0]);
        rsel = 1'b0;
      end
    end
    done_prev = (uio_out[7] === 1'b1);
  end

  // Driver tasks
  task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs);
    @(negedge clk);
    ui_in   = dvd;
    divisor = dvs;
    start   = 1'b1;
    @(posedge clk);
    #1;
    check1("busy_at_start", uio_out[6], 1'b1);
    check1("done_at_start", uio_out[7], 1'b0);
  endtask

  // Counts edges until done; while running, busy must be high and the old result held.
  task automatic wait_done(input logic toggle, output int cycles);
    cycles = 0;
    while (uio_out[7] !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (uio_out[7] !== 1'b1) begin
        check1("busy_running", uio_out[6], 1'b1);
        check8("result_held", uo_out, prev_quot);
      end
      if (toggle) begin
        start = (cycles < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        ui_in = 8'($urandom_range(0, 255));
        divisor = 4'($urandom_range(0, 15));
      end
    end
    check1("busy_at_done", uio_out[6], 1'b0);
  endtask

  task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs,
                       input logic [15:0] exp, input logic toggle);
    int cyc;
    exp_q.push_back(exp);
    start_op(dvd, dvs);
    if (!toggle) start = 1'b0;
    wait_done(toggle, cyc);
    start = 1'b0;
    checki("latency", cyc, 8);
    prev_quot = exp[15:8];
  endtask

  initial begin
    int cyc;

    // Reset state
    #1;
    check1("reset_busy", uio_out[6], 1'b0);
    check1("reset_done", uio_out[7], 1'b0);
    check8("reset_uo_q", uo_out, 8'h00);
    check8("uio_oe", uio_oe, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, hand-computed
    do_op(8'd225, 4'd15, {8'h0F, 8'h00}, 1'b0);
    do_op(8'd200, 4'd7,  {8'h1C, 8'h04}, 1'b0);
    do_op(8'hA7,  4'd0,  {8'hFF, 8'h87}, 1'b0);
    do_op(8'd255, 4'd1,  {8'hFF, 8'h00}, 1'b0);
    do_op(8'd0,   4'd5,  {8'h00, 8'h00}, 1'b0);
    do_op(8'd14,  4'd15, {8'h00, 8'h0E}, 1'b0);
    do_op(8'd255, 4'd15, {8'h11, 8'h00}, 1'b0);
    do_op(8'd0,   4'd0,  {8'hFF, 8'h80}, 1'b0);

    // start and operands wiggle during RUN: 123/10 = 12 r 3
    do_op(8'd123, 4'd10, {8'h0C, 8'h03}, 1'b1);

    // start held through DONE: 100/9 = 11 r 1, then 77/4 = 19 r 1
    exp_q.push_back({8'h0B, 8'h01});
    exp_q.push_back({8'h13, 8'h01});
    start_op(8'd100, 4'd9);
    ui_in   = 8'd77;
    divisor = 4'd4;
    wait_done(1'b0, cyc);
    checki("hold_latency_a", cyc, 8);
    prev_quot = 8'h0B;
    @(posedge clk);
    #1;
    start = 1'b0;
    check1("hold_done_drop", uio_out[7], 1'b0);
    check1("hold_busy", uio_out[6], 1'b1);
    check8("hold_prev_visible", uo_out, 8'h0B);
    wait_done(1'b0, cyc);
    checki("hold_latency_b", cyc, 8);
    prev_quot = 8'h13;

    // Reset mid-RUN aborts with no result
    start_op(8'h55, 4'd3);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("abort_busy", uio_out[6], 1'b0);
    check1("abort_done", uio_out[7], 1'b0);
    check8("abort_uo_q", uo_out, 8'h00);
    rsel = 1'b1;
    #1;
    check8("abort_uo_r", uo_out, 8'h00);
    rsel = 1'b0;
    prev_quot = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      check1("post_reset_no_done", uio_out[7], 1'b0);
      check1("post_reset_idle", uio_out[6], 1'b0);
    end

    // Exhaustive sweep against integer division
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a), 4'(b), {8'(a / b), 4'b0000, 4'(a % b)}, 1'b0);
      end
    end

    repeat (4) @(posedge clk);
    #5;
    checki("queue_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_seq_divider_8by4.md
Name: tt_um_seq_divider_8by4

Overview:
- Sequential restoring divider. It is the inverse of the team's 4x4 array multiplier: it takes an 8-bit product-sized dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder.
- It resolves one quotient bit per clock, using a start/busy/done handshake.
- It is a Tiny Tapeout top-level tile that uses the standard tt_um pin set.

Parameters:
- None. Widths are fixed by the pin map: dividend 8, divisor 4, quotient 8, remainder 4.

Ports:
- clk  in  1  Clock. The design has a single clock.
- rst_n  in  1  Reset. Asynchronous, active-low.
- ena  in  1  Ignored.
- ui_in  in  8  Dividend[7:0].
- uio_in  in  8  [3:0] divisor, [4] start, [5] rsel. Bits [7:6] are unused as inputs.
- uo_out  out  8  Result view.
  - rsel=0: quotient[7:0].
  - rsel=1: {dbz, 3'b000, remainder[3:0]}.
- uio_out  out  8  [6] busy, [7] done. All other bits are 0.
- uio_oe  out  8  Constant 8'b1100_0000.

Behaviour:
- Reset: the asynchronous reset on rst_n=0 forces the following:
  - state=IDLE.
  - Quotient, remainder and dbz result registers = 0.
  - Working registers = 0.
  - Iteration counter = 0.
  - busy=0, done=0, so uo_out=0 for either rsel value.
  - Reset mid-RUN aborts the operation immediately. No result is written.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 at a rising edge E:
  - Latch dividend into shift register dq[7:0] and divisor into dv[3:0].
  - Clear the partial remainder pr[4:0] and the counter.
  - Go to RUN.
  - start is level-sampled. Holding it high in DONE restarts a new operation on every DONE edge.
- RUN, at each edge:
  - t = {pr[3:0], dq[7]} (5 bits).
  - If t >= {1'b0, dv}: pr <= t - dv and the new quotient bit = 1. Otherwise pr <= t and the bit = 0.
  - dq <= {dq[6:0], qbit}.
  - Counter increments.
- Iteration 8 completes at edge E+8. Then:
  - state <= DONE.
  - quotient <= final dq.
  - remainder <= final pr[3:0].
  - dbz <= (dv==0).
- start is ignored throughout RUN.
- Divide-by-zero (dv==0):
  - Latency is still the full 8 cycles.
  - The result is overridden: quotient=8'hFF, remainder=dividend[3:0] (the latched value), dbz=1.
- busy=1 exactly when state==RUN. It is high from after edge E until edge E+8.
- done=1 exactly when state==DONE. It stays high until the next accepted start, then drops on that edge.
- Result registers hold the last completed result through IDLE, RUN and DONE. They change only at completion edges or at reset.
- Invariant for dv!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Overflow is impossible: the quotient fits in 8 bits for every divisor >= 1.
- rsel is purely combinational on the output mux. It has no effect on the state machine.
- Every output is a register or a mux of registers. There are no combinational paths from ui_in or uio_in[4:0] to outputs.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → busy=0, done=0, uo_out=0 immediately. After release, state IDLE and no done pulse.
- Basic division:
  - Dividend 8'd225 (0xE1), divisor 4'd15, pulse start 1 cycle.
  - Required: busy for 8 cycles, then done=1.
  - rsel=0 → uo_out=0x0F. rsel=1 → uo_out=0x00.
- Remainder case:
  - Dividend 8'd200, divisor 4'd7.
  - Required: quotient 28 (0x1C), remainder 4, uo_out with rsel=1 = 0x04.
  - done asserts at E+8 exactly.
- Divide-by-zero:
  - Dividend 0xA7, divisor 0.
  - Required: after 8 cycles done=1, quotient 0xFF, rsel=1 → uo_out=0x87 (dbz=1, remainder 7).
- Handshake edge cases:
  - Toggle start during RUN → ignored, result unchanged.
  - Hold start high in DONE → new operation starts, done drops for 8 cycles, previous result remains visible until the new completion.
- Exhaustive sweep: every dividend 0..255 × divisor 1..15 → quotient and remainder match integer division. Latency is always 8 cycles.
